// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE engine controller: FSM states and the
// read-to-psum latency of the operand buffer + PE + engine register path.
package pe_ctrl_pkg;

    // Cycles from a buffer read strobe to its product appearing on psum
    localparam int PE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pe_lane_acc.sv
// Single-lane accumulator: synchronous clear at job start, zero-extended add
// of the lane product when enabled, wrapping modulo 2^AccWidth.
module pe_lane_acc #(
    parameter int PsumWidth = 16,
    parameter int AccWidth  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [PsumWidth-1:0] psum_i,
    output logic [AccWidth-1:0]  acc_o
);

    logic [AccWidth-1:0] acc_q;

    // Clear has priority over accumulate; both happen on the same edge only at job start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + AccWidth'(psum_i);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_engine_ctrl.sv
// PE engine controller: streams len chunk reads from the ifmap/filter buffers,
// accumulates the returning lane products once they emerge from the fixed
// latency pipeline, and holds the result until the consumer accepts it.
module pe_engine_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int Size      = 9,
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8,
    parameter int AccWidth  = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [AddrWidth-1:0]          base_if,
    input  logic [AddrWidth-1:0]          base_f,
    input  logic [AddrWidth:0]            len,
    output logic                          rd_en,
    output logic [AddrWidth-1:0]          rd_addr_if,
    output logic [AddrWidth-1:0]          rd_addr_f,
    input  logic [2*Size*DataWidth-1:0]   psum,
    output logic [Size*AccWidth-1:0]      acc_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int PsumWidth = 2 * DataWidth;
    localparam logic [AddrWidth:0] LenOne = 1;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  base_if_q, base_f_q;
    logic [AddrWidth:0]    len_q, idx_q;
    logic [PE_LAT-1:0]     vld_q, vld_d;
    logic                  start_acc;
    logic                  last_issue;
    logic                  acc_en;

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign last_issue = (idx_q == (len_q - LenOne));
    // Bit 0 tracks reads issued this cycle; the top bit marks psum valid now
    assign vld_d      = {vld_q[PE_LAT-2:0], rd_en};
    assign acc_en     = vld_q[PE_LAT-1] && (state_q != ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: DRAIN exits once the final product has been folded in
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (vld_d == '0) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; addresses read as zero when not strobing
    always_comb begin
        rd_en      = (state_q == ST_FETCH);
        busy       = (state_q != ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        rd_addr_if = '0;
        rd_addr_f  = '0;
        if (rd_en) begin
            rd_addr_if = base_if_q + idx_q[AddrWidth-1:0];
            rd_addr_f  = base_f_q + idx_q[AddrWidth-1:0];
        end
    end

    // Job parameters, issue counter and read-valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_if_q <= '0;
            base_f_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            vld_q     <= '0;
        end else begin
            vld_q <= vld_d;
            if (start_acc) begin
                base_if_q <= base_if;
                base_f_q  <= base_f;
                len_q     <= len;
                idx_q     <= '0;
            end else if (rd_en) begin
                idx_q <= idx_q + LenOne;
            end
        end
    end

    for (genvar i = 0; i < Size; i++) begin : g_lane
        pe_lane_acc #(
            .PsumWidth (PsumWidth),
            .AccWidth  (AccWidth)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (start_acc),
            .en_i   (acc_en),
            .psum_i (psum[(i+1)*PsumWidth-1 -: PsumWidth]),
            .acc_o  (acc_out[(i+1)*AccWidth-1 -: AccWidth])
        );
    end

endmodule

// File: tb/tb_pe_engine_ctrl.sv
// Bench for pe_engine_ctrl: operand buffers + PE engine model feed psum with a
// 3-cycle read latency; a dot-product reference model predicts each result.
module tb_pe_engine_ctrl;

    localparam int SIZE = 9;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int ACCW = 16;
    localparam int PW   = 2 * DW;

    typedef logic [SIZE*ACCW-1:0] accv_t;
    typedef struct { accv_t acc; int t0; int lat; } exp_t;
    typedef struct { logic [AW-1:0] a_if; logic [AW-1:0] a_f; } addr_t;

    logic                 clk, rst_n, start, rd_en, out_valid, out_ready, busy;
    logic [AW-1:0]        base_if, base_f, rd_addr_if, rd_addr_f;
    logic [AW:0]          len;
    logic [SIZE*PW-1:0]   psum;
    logic [SIZE*ACCW-1:0] acc_out;

    logic [7:0]           ifmem [256][SIZE];
    logic [7:0]           fmem  [256][SIZE];
    logic [SIZE*DW-1:0]   brd_if, brd_f;
    logic [SIZE*PW-1:0]   prod_q;
    bit                   force_ff, hold_rdy;

    exp_t  exp_q[$];
    addr_t addr_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    pe_engine_ctrl #(.Size(SIZE), .DataWidth(DW), .AddrWidth(AW), .AccWidth(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_if(base_if), .base_f(base_f),
        .len(len), .rd_en(rd_en), .rd_addr_if(rd_addr_if), .rd_addr_f(rd_addr_f),
        .psum(psum), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer read -> PE multiply -> engine register, one cycle each
    always @(posedge clk) begin
        for (int l = 0; l < SIZE; l++) begin
            if (rd_en) begin
                brd_if[l*DW +: DW] <= ifmem[rd_addr_if][l];
                brd_f[l*DW +: DW]  <= fmem[rd_addr_f][l];
            end
            prod_q[l*PW +: PW] <= PW'(brd_if[l*DW +: DW]) * PW'(brd_f[l*DW +: DW]);
        end
        psum <= force_ff ? '1 : prod_q;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: per-lane dot product of the addressed chunks, modulo 2^ACCW
    function automatic accv_t model(input int bif, input int bf, input int L, input bit frc);
        accv_t r;
        r = '0;
        for (int l = 0; l < SIZE; l++) begin
            longint s = 0;
            for (int j = 0; j < L; j++)
                s += frc ? 65535 : int'(ifmem[(bif + j) % 256][l]) * int'(fmem[(bf + j) % 256][l]);
            r[l*ACCW +: ACCW] = ACCW'(s % (longint'(1) << ACCW));
        end
        return r;
    endfunction

    task automatic fill_rand();
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < SIZE; l++) begin
                ifmem[a][l] = 8'($urandom);
                fmem[a][l]  = 8'($urandom);
            end
    endtask

    task automatic fill_all(input logic [7:0] vi, input logic [7:0] vf);
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < SIZE; l++) begin
                ifmem[a][l] = vi;
                fmem[a][l]  = vf;
            end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0) begin
            tick();
            if (++k > 3000) begin
                chk("wait_idle_timeout", 256'(busy), 256'(0));
                break;
            end
        end
    endtask

    task automatic issue_job(input int bif, input int bf, input int L, input bit frc);
        exp_t e;
        e.acc = model(bif, bf, L, frc);
        e.t0  = cyc;
        e.lat = (L == 0) ? 1 : L + 4;
        exp_q.push_back(e);
        for (int j = 0; j < L; j++) begin
            addr_t a;
            a.a_if = 8'((bif + j) % 256);
            a.a_f  = 8'((bf + j) % 256);
            addr_q.push_back(a);
        end
        base_if = 8'(bif);
        base_f  = 8'(bf);
        len     = 9'(L);
        start   = 1;
        tick();
        start   = 0;
    endtask

    // Run out the job; optionally toss stray start pulses while busy
    task automatic finish_job(input bit noise);
        int k = 0;
        while (1) begin
            tick();
            start = 0;
            if (busy !== 1'b1) break;
            if (++k > 3000) begin
                chk("job_timeout", 256'(busy), 256'(0));
                break;
            end
            if (noise && ($urandom % 4 == 0)) begin
                start   = 1;
                base_if = 8'($urandom);
                len     = 9'($urandom);
            end
        end
    endtask

    task automatic run_job(input int bif, input int bf, input int L, input bit frc, input bit noise);
        wait_idle();
        issue_job(bif, bf, L, frc);
        finish_job(noise);
    endtask

    // Consumer: random back-pressure unless held off
    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = hold_rdy ? 1'b0 : ($urandom % 3 != 0);
        end
    end

    // Monitor: read-address scoreboard, result scoreboard, handshake follow-up
    initial begin
        exp_t  cur;
        addr_t a;
        bit    have_cur = 0, prev_v = 0, pend_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_cur = 0;
                prev_v   = 0;
                pend_hs  = 0;
            end else begin
                if (rd_en) begin
                    chk("rd_while_busy", 256'(busy), 256'(1));
                    if (addr_q.size() == 0) begin
                        chk("rd_unexpected", 256'(rd_en), 256'(0));
                    end else begin
                        a = addr_q.pop_front();
                        chk("rd_addr", 256'({rd_addr_if, rd_addr_f}), 256'({a.a_if, a.a_f}));
                    end
                end
                if (pend_hs) chk("idle_after_accept", 256'({busy, out_valid}), 256'(0));
                if (out_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        chk("result_unexpected", 256'(out_valid), 256'(0));
                        have_cur = 0;
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1;
                        chk("acc_out", 256'(acc_out), 256'(cur.acc));
                        chk("latency", 256'(cyc - cur.t0), 256'(cur.lat));
                        chk("rd_count", 256'(addr_q.size()), 256'(0));
                    end
                end else if (out_valid && have_cur) begin
                    chk("acc_stable", 256'(acc_out), 256'(cur.acc));
                end
                pend_hs = out_valid && out_ready;
                prev_v  = out_valid;
            end
        end
    end

    initial begin
        rst_n = 0; start = 0; base_if = 0; base_f = 0; len = 0;
        force_ff = 0; hold_rdy = 0;
        fill_rand();
        repeat (3) tick();
        chk("reset_ctrl", 256'({busy, out_valid, rd_en, rd_addr_if, rd_addr_f}), 256'(0));
        chk("reset_acc", 256'(acc_out), 256'(0));
        rst_n = 1;
        tick();
        chk("idle_ctrl", 256'({busy, out_valid, rd_en}), 256'(0));

        // Single chunk of all-2 operands: every lane 4
        fill_all(8'd2, 8'd2);
        run_job(0, 0, 1, 0, 0);

        // Four chunks, ifmap lane i = i+1, filter 3: lane i = 12*(i+1)
        fill_rand();
        for (int j = 0; j < 4; j++)
            for (int l = 0; l < SIZE; l++) begin
                ifmem[8'h10 + j][l] = 8'(l + 1);
                fmem[8'h20 + j][l]  = 8'd3;
            end
        run_job(8'h10, 8'h20, 4, 0, 0);

        // Empty job
        run_job(5, 7, 0, 0, 1);

        // Address wrap past the top of the buffer
        run_job(8'hFE, 8'hFE, 4, 0, 0);

        // Accumulator wrap: two 0xFFFF products -> 0xFFFE
        force_ff = 1;
        run_job(3, 9, 2, 1, 0);
        force_ff = 0;

        // Consumer stalls in DONE while start is pulsed
        hold_rdy = 1;
        wait_idle();
        issue_job(8'h30, 8'h31, 3, 0);
        begin
            int k = 0;
            while (out_valid !== 1'b1 && k < 100) begin tick(); k++; end
            chk("done_reached", 256'(out_valid), 256'(1));
        end
        for (int i = 0; i < 10; i++) begin
            start   = (i % 2 == 0);
            base_if = 8'($urandom);
            len     = 9'($urandom_range(1, 9));
            tick();
        end
        start = 0;
        chk("done_held", 256'({busy, out_valid}), 256'(3));
        hold_rdy = 0;
        finish_job(0);
        repeat (3) begin
            tick();
            chk("start_ignored", 256'({busy, rd_en}), 256'(0));
        end

        // Reset in the middle of FETCH, then a fresh single-chunk job
        wait_idle();
        fill_rand();
        issue_job(8'h50, 8'h60, 8, 0);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("midjob_rst_ctrl", 256'({busy, out_valid, rd_en, rd_addr_if, rd_addr_f}), 256'(0));
        chk("midjob_rst_acc", 256'(acc_out), 256'(0));
        exp_q.delete();
        addr_q.delete();
        tick();
        tick();
        rst_n = 1;
        run_job(8'h51, 8'h61, 1, 0, 0);

        // Randomized jobs with stray starts while busy
        for (int n = 0; n < 25; n++) begin
            int L;
            if (n % 5 == 0) fill_rand();
            L = (n == 12) ? 256 : $urandom_range(0, 12);
            run_job($urandom_range(0, 255), $urandom_range(0, 255), L, 0, 1);
        end

        repeat (5) tick();
        chk("results_drained", 256'(exp_q.size()), 256'(0));
        chk("reads_drained", 256'(addr_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_engine_ctrl.md
PE_ENGINE_CTRL -- requirements
Module: pe_engine_ctrl

Interface
REQ-001 Parameter Size, default 9, number of PE lanes.
REQ-002 Parameter DataWidth, default 8, ifmap/filter element width.
REQ-003 Parameter AddrWidth, default 8, operand-buffer address width.
REQ-004 Parameter AccWidth, default 24, per-lane accumulator width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  begin a job; sampled only in IDLE.
REQ-008 base_if  in  AddrWidth  first ifmap-buffer word address.
REQ-009 base_f  in  AddrWidth  first filter-buffer word address.
REQ-010 len  in  AddrWidth+1  number of Size-wide chunks to accumulate (0..2^AddrWidth).
REQ-011 rd_en  out  1  read strobe to both operand buffers.
REQ-012 rd_addr_if / rd_addr_f  out  AddrWidth  buffer read addresses.
REQ-013 psum  in  2*Size*DataWidth  lane products from the PE engine, lane i at bits [(i+1)*16-1 -: 16].
REQ-014 acc_out  out  Size*AccWidth  lane sums, lane i at [(i+1)*AccWidth-1 -: AccWidth].
REQ-015 out_valid  out  1  acc_out holds a finished result.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL latch base_if, base_f, len, clear all accumulators, and go to FETCH (len>0) or DONE (len=0).
REQ-020 FETCH: one rd_en per cycle, addresses base+0 .. base+len-1 (mod 2^AddrWidth, wrap allowed); after the last issue go to DRAIN.
REQ-021 Read-to-psum latency SHALL be exactly 3 cycles (buffer 1, PE 1, engine register 1), tracked by a 3-stage valid shift register fed by rd_en.
REQ-022 When stage-3 valid is high, each lane SHALL add zero-extended psum slice to its accumulator, wrapping modulo 2^AccWidth.
REQ-023 DRAIN SHALL go to DONE in the cycle after the shift register is empty (the last accumulate has landed).
REQ-024 DONE: out_valid=1, acc_out stable; on out_valid&&out_ready return to IDLE next cycle.
REQ-025 start while busy SHALL be ignored; no queuing.
REQ-026 A job with len=L SHALL take L+4 cycles from start sample to out_valid rising (len=0: 1 cycle).
REQ-027 Accumulators SHALL NOT change outside stage-3 valid cycles or in DONE.
REQ-028 rd_en SHALL be 0 in IDLE, DRAIN, DONE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, rd_en=0, addresses=0, valid pipeline=0, accumulators=0, out_valid=0, busy=0.
REQ-030 Reset mid-job SHALL abandon the job; in-flight psum values SHALL NOT be accumulated after release.

Structure
REQ-031 State encoding and latency constant (PE_LAT=3) SHALL live in a shared package pe_ctrl_pkg.
REQ-032 One sub-module, pe_lane_acc (single-lane clear/accumulate register), SHALL be instantiated Size times.

Verification
REQ-033 len=1, buffers all 2, psum driven by a PE-engine model -> out_valid at cycle 5 after start, every lane = 4.
REQ-034 len=4, ifmap lane i = i+1, filter = 3 -> lane i = 12*(i+1); exactly 4 rd_en pulses, addresses base..base+3.
REQ-035 len=0 -> out_valid next cycle, all lanes 0, no rd_en.
REQ-036 base=0xFE, len=4 -> addresses 0xFE,0xFF,0x00,0x01; AccWidth=16 with products 0xFFFF over len=2 -> lane = 0xFFFE.
REQ-037 out_ready held low 10 cycles in DONE, start pulsed -> acc_out stable, start ignored, IDLE one cycle after out_ready.
REQ-038 rst_n asserted during FETCH of len=8 -> outputs zero at once; new len=1 job after release yields correct single-product result.
